// File: rtl/board_clear_master_pkg.sv
// Shared constants and state encoding for the hardware board-clear master.
// Addresses are word addresses into the display slave's register window.
package board_clear_master_pkg;

    localparam logic [11:0] LEVEL_LINES_ADDR = 12'h000;
    localparam logic [11:0] ROW0_ADDR        = 12'h002;
    localparam logic [1:0]  EMPTY_CELL       = 2'b00;
    localparam int          NUM_ROWS         = 20;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD      = 4'd1,
        S_WAIT    = 4'd2,
        S_EVAL    = 4'd3,
        S_WR      = 4'd4,
        S_FILL    = 4'd5,
        S_LC_RD   = 4'd6,
        S_LC_WAIT = 4'd7,
        S_LC_WR   = 4'd8,
        S_FIN     = 4'd9
    } bcm_state_t;

endpackage

// File: rtl/board_clear_master_bcd4_add_sat.sv
// Four-digit packed BCD plus a small binary increment, clamped at 9999.
// Also suitable for the score path.
module bcd4_add_sat (
    input  logic [15:0] bcd_in,
    input  logic [2:0]  inc,
    output logic [15:0] bcd_out
);

    logic [4:0]  carry;
    logic [4:0]  sum;
    logic [15:0] res;

    always_comb begin
        carry = {2'b00, inc};
        sum   = 5'd0;
        res   = 16'h0000;
        // The first digit absorbs the whole increment; higher digits see 0/1.
        for (int d = 0; d < 4; d++) begin
            sum = {1'b0, bcd_in[4*d +: 4]} + carry;
            if (sum >= 5'd10) begin
                sum   = sum - 5'd10;
                carry = 5'd1;
            end else begin
                carry = 5'd0;
            end
            res[4*d +: 4] = sum[3:0];
        end
        bcd_out = (carry != 5'd0) ? 16'h9999 : res;
    end

endmodule

// File: rtl/board_clear_master.sv
// Avalon-MM master that removes full rows from the display board, compacts
// the rest downward, blanks the vacated top rows and bumps the BCD line count.
module board_clear_master
    import board_clear_master_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int NUM_ROWS     = 20,
    parameter int NUM_COLS     = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  LINES_CLEARED,
    output logic        AVM_CS,
    output logic        AVM_READ,
    output logic        AVM_WRITE,
    output logic [11:0] AVM_ADDR,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic [31:0] AVM_READDATA
);

    localparam logic [4:0] LAST_ROW = 5'(NUM_ROWS - 1);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    bcm_state_t  state_q, state_d;
    logic [4:0]  src_q, src_d;
    logic [4:0]  dst_q, dst_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  lines_cleared_q, lines_cleared_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] row_q, row_d;
    logic [15:0] lines_q, lines_d;

    logic        row_full;
    logic        step;
    logic [15:0] lines_sum;
    logic        rd, wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;

    function automatic logic [11:0] row_addr(input logic [4:0] ptr);
        return ROW0_ADDR + {7'd0, ptr};
    endfunction

    bcd4_add_sat u_lines_add (
        .bcd_in  (lines_q),
        .inc     (cnt_q),
        .bcd_out (lines_sum)
    );

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < NUM_COLS; c++)
            if (row_q[2*c +: 2] == EMPTY_CELL) row_full = 1'b0;
    end

    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        cnt_d           = cnt_q;
        lines_cleared_d = lines_cleared_q;
        lat_d           = lat_q;
        row_d           = row_q;
        lines_d         = lines_q;
        step            = 1'b0;
        rd              = 1'b0;
        wr              = 1'b0;
        addr            = 12'h000;
        be              = 4'h0;
        wdata           = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    src_d           = LAST_ROW;
                    dst_d           = LAST_ROW;
                    cnt_d           = 3'd0;
                    lines_cleared_d = 3'd0;
                    state_d         = S_RD;
                end
            end
            S_RD: begin
                rd      = 1'b1;
                addr    = row_addr(src_q);
                be      = 4'hF;
                lat_d   = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    row_d   = AVM_READDATA;
                    state_d = S_EVAL;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_EVAL: begin
                if (row_full) begin
                    cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
                    step  = 1'b1;
                end else if (src_q != dst_q) begin
                    state_d = S_WR;
                end else begin
                    dst_d = dst_q - 5'd1;
                    step  = 1'b1;
                end
            end
            S_WR: begin
                wr    = 1'b1;
                addr  = row_addr(dst_q);
                be    = 4'hF;
                wdata = row_q;
                dst_d = dst_q - 5'd1;
                step  = 1'b1;
            end
            S_FILL: begin
                // After compaction dst sits at cnt-1, so this blanks exactly cnt rows.
                wr    = 1'b1;
                addr  = row_addr(dst_q);
                be    = 4'hF;
                dst_d = dst_q - 5'd1;
                if (dst_q == 5'd0) state_d = S_LC_RD;
            end
            S_LC_RD: begin
                rd      = 1'b1;
                addr    = LEVEL_LINES_ADDR;
                be      = 4'hF;
                lat_d   = 2'd0;
                state_d = S_LC_WAIT;
            end
            S_LC_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    lines_d = AVM_READDATA[15:0];
                    state_d = S_LC_WR;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_LC_WR: begin
                wr      = 1'b1;
                addr    = LEVEL_LINES_ADDR;
                be      = 4'h3;
                wdata   = {16'h0000, lines_sum};
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared source-row advance for EVAL and WR; an empty pass skips fill and line update.
        if (step) begin
            if (src_q == 5'd0) begin
                state_d = (cnt_d == 3'd0) ? S_FIN : S_FILL;
            end else begin
                src_d   = src_q - 5'd1;
                state_d = S_RD;
            end
        end

        if (state_d == S_FIN) lines_cleared_d = cnt_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= S_IDLE;
            src_q           <= 5'd0;
            dst_q           <= 5'd0;
            cnt_q           <= 3'd0;
            lines_cleared_q <= 3'd0;
            lat_q           <= 2'd0;
            row_q           <= 32'h0;
            lines_q         <= 16'h0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            cnt_q           <= cnt_d;
            lines_cleared_q <= lines_cleared_d;
            lat_q           <= lat_d;
            row_q           <= row_d;
            lines_q         <= lines_d;
        end
    end

    assign BUSY          = (state_q != S_IDLE) && (state_q != S_FIN);
    assign DONE          = (state_q == S_FIN);
    assign LINES_CLEARED = lines_cleared_q;
    assign AVM_CS        = rd | wr;
    assign AVM_READ      = rd;
    assign AVM_WRITE     = wr;
    assign AVM_ADDR      = addr;
    assign AVM_BYTE_EN   = be;
    assign AVM_WRITEDATA = wdata;

endmodule
